// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scanner: one shared BCD decoder, guard gap
// between digits, shadow/active registers with a tear-free commit at frame end.

module bcd7seg (
  input  logic [3:0] num,
  output logic [6:0] seg
);
  // Active-low, bit order {g,f,e,d,c,b,a}
  always_comb begin
    case (num)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] val,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        pending,
  output logic        frame_done,
  output logic        bad_digit
);
  localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] G_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DIV - 1);

  typedef enum logic {ST_GUARD, ST_SHOW} state_t;

  state_t        state, state_n;
  logic [1:0]    d, d_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   active, shadow, hi;
  logic [3:0]    nib, an_n;
  logic [6:0]    dec, seg_n;
  logic          show_entry, commit, bad_n, lz_off;

  bcd7seg u_dec (.num(nib), .seg(dec));

  // d only advances when leaving SHOW, so during GUARD it already names the
  // digit about to be shown and the decoder output is ready for the entry edge.
  assign nib        = active[{d, 2'b00} +: 4];
  assign hi         = active >> {d, 2'b00};
  assign lz_off     = lz_blank && (d != 2'd0) && (hi == 16'h0000);
  assign show_entry = (state == ST_GUARD) && (cnt == G_LAST);
  assign commit     = (state == ST_SHOW) && (cnt == D_LAST) && (d == 2'd3);
  assign bad_n      = show_entry && (nib > 4'd9);

  always_comb begin
    state_n = state;
    d_n     = d;
    cnt_n   = cnt + CW'(1);
    an_n    = 4'hF;
    seg_n   = 7'h7F;
    case (state)
      ST_GUARD: if (cnt == G_LAST) begin
        state_n = ST_SHOW;
        cnt_n   = '0;
      end
      ST_SHOW: if (cnt == D_LAST) begin
        state_n = ST_GUARD;
        cnt_n   = '0;
        d_n     = d + 2'd1;
      end
      default: begin
        state_n = ST_GUARD;
        cnt_n   = '0;
      end
    endcase
    if (state_n == ST_SHOW && nib <= 4'd9 && !lz_off) begin
      an_n  = ~(4'b0001 << d);
      seg_n = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_GUARD;
      d          <= 2'd0;
      cnt        <= '0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      active     <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      bad_digit  <= 1'b0;
    end else begin
      state      <= state_n;
      d          <= d_n;
      cnt        <= cnt_n;
      an         <= an_n;
      seg        <= seg_n;
      frame_done <= commit;
      bad_digit  <= bad_n;
      if (commit && pending) active <= shadow;
      // A load on the commit edge still wins for shadow and keeps pending set
      if (load) begin
        shadow  <= val;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4, GUARD=1 (20-cycle frame).

module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, load, lz_blank;
  logic [15:0] val;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pending, frame_done, bad_digit;
  int          tests = 0;
  int          fails = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000,
                         BL = 7'h7F;

  seg_scan_ctrl #(.DIV(4), .GUARD(1)) dut (
    .clk(clk), .rst(rst), .load(load), .val(val), .lz_blank(lz_blank),
    .an(an), .seg(seg), .pending(pending), .frame_done(frame_done),
    .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at the frame-boundary guard cycle; segs = {d3,d2,d1,d0}, 7F = blank.
  task automatic run_frame(input string nm, input logic [27:0] segs, input logic [3:0] badm,
                           input bit pend_in, input int l1, input logic [15:0] v1,
                           input int l2, input logic [15:0] v2,
                           input int l3, input logic [15:0] v3);
    for (int i = 1; i <= 20; i++) begin
      int dg;
      logic [6:0] es;
      logic [3:0] ea;
      logic ep, eb;
      load = 1'b0;
      if (l1 == i) begin load = 1'b1; val = v1; end
      if (l2 == i) begin load = 1'b1; val = v2; end
      if (l3 == i) begin load = 1'b1; val = v3; end
      tick();
      load = 1'b0;
      dg = (i - 1) / 5;
      if (i % 5 == 0) begin
        es = BL; ea = 4'hF; eb = 1'b0;
      end else begin
        es = segs[dg*7 +: 7];
        ea = (es == BL) ? 4'hF : ~(4'b0001 << dg);
        eb = (i % 5 == 1) && badm[dg];
      end
      if (i == 20) ep = (l1 == 20) || (l2 == 20) || (l3 == 20);
      else ep = pend_in || (l1 != 0 && i >= l1) || (l2 != 0 && i >= l2) || (l3 != 0 && i >= l3);
      chk($sformatf("%s.c%0d.an", nm, i), 16'(an), 16'(ea));
      chk($sformatf("%s.c%0d.seg", nm, i), 16'(seg), 16'(es));
      chk($sformatf("%s.c%0d.fd", nm, i), 16'(frame_done), 16'(i == 20));
      chk($sformatf("%s.c%0d.bad", nm, i), 16'(bad_digit), 16'(eb));
      chk($sformatf("%s.c%0d.pend", nm, i), 16'(pending), 16'(ep));
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lz_blank = 1'b0; val = 16'h0000;
    tick(); tick();
    chk("rst.an", 16'(an), 16'hF);
    chk("rst.seg", 16'(seg), 16'h7F);
    chk("rst.pend", 16'(pending), 16'h0);
    chk("rst.fd", 16'(frame_done), 16'h0);
    chk("rst.bad", 16'(bad_digit), 16'h0);

    rst = 1'b0;
    tick();
    chk("first.an", 16'(an), 16'hE);
    chk("first.seg", 16'(seg), 16'(S0));
    for (int i = 0; i < 19; i++) tick();
    chk("f1.fd", 16'(frame_done), 16'h1);
    chk("f1.an", 16'(an), 16'hF);

    // Zeros shown everywhere; 1234 loaded mid-frame
    run_frame("f2", {S0, S0, S0, S0}, 4'b0, 1'b0, 7, 16'h1234, 0, 16'h0, 0, 16'h0);
    run_frame("f3", {S1, S2, S3, S4}, 4'b0, 1'b0, 3, 16'h0042, 0, 16'h0, 0, 16'h0);
    run_frame("f4", {S0, S0, S4, S2}, 4'b0, 1'b0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    lz_blank = 1'b1;
    run_frame("f5", {BL, BL, S4, S2}, 4'b0, 1'b0, 2, 16'h0000, 0, 16'h0, 0, 16'h0);
    run_frame("f6", {BL, BL, BL, S0}, 4'b0, 1'b0, 9, 16'h00A7, 0, 16'h0, 0, 16'h0);
    lz_blank = 1'b0;
    run_frame("f7", {S0, S0, BL, S7}, 4'b0010, 1'b0, 3, 16'h1111, 8, 16'h2222, 20, 16'h3333);
    run_frame("f8", {S2, S2, S2, S2}, 4'b0, 1'b1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    run_frame("f9", {S3, S3, S3, S3}, 4'b0, 1'b0, 0, 16'h0, 0, 16'h0, 0, 16'h0);

    // Reset mid digit-2 dwell with a pending value
    load = 1'b1; val = 16'h5678;
    tick();
    load = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("pre_rst.an", 16'(an), 16'hB);
    chk("pre_rst.seg", 16'(seg), 16'(S3));
    chk("pre_rst.pend", 16'(pending), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst.an", 16'(an), 16'hF);
    chk("mid_rst.seg", 16'(seg), 16'h7F);
    chk("mid_rst.pend", 16'(pending), 16'h0);
    chk("mid_rst.fd", 16'(frame_done), 16'h0);
    tick();
    chk("post_rst.an", 16'(an), 16'hE);
    chk("post_rst.seg", 16'(seg), 16'(S0));
    for (int i = 0; i < 19; i++) tick();
    chk("post_rst.fd", 16'(frame_done), 16'h1);
    run_frame("f10", {S0, S0, S0, S0}, 4'b0, 1'b0, 0, 16'h0, 0, 16'h0, 0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: clock cycles each digit is driven (dwell); SHALL be >= 1.
REQ-002 Parameter GUARD, default 2: all-off cycles before each digit dwell (anti-ghosting); SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL change on posedge clk only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 load  input  1  one-cycle request to capture val into the shadow register.
REQ-006 val  input  16  four BCD digits; val[3:0] is digit 0 (LS), val[15:12] is digit 3 (MS).
REQ-007 lz_blank  input  1  1 = suppress leading zeros.
REQ-008 an  output  4  digit enables, active-low, registered; an[d] drives digit d.
REQ-009 seg  output  7  segments, active-low, registered; 7'h7F = blank.
REQ-010 pending  output  1  shadow holds a value not yet committed to the display.
REQ-011 frame_done  output  1  one-cycle pulse at end of each 4-digit scan frame.
REQ-012 bad_digit  output  1  one-cycle pulse when a digit > 9 is scheduled for display.

Function
REQ-013 Block SHALL contain exactly one bcd7seg instance, time-shared across all four digits; its num input SHALL be the active-register nibble of the current digit.
REQ-014 FSM SHALL have states GUARD and SHOW, plus a 2-bit digit index d and a dwell counter cnt.
REQ-015 GUARD: an = 4'hF, seg = 7'h7F; cnt counts 0..GUARD-1; at GUARD-1 -> SHOW, cnt <= 0.
REQ-016 SHOW: an[d] = 0, others 1; seg = decoder output; cnt counts 0..DIV-1; at DIV-1 -> GUARD, cnt <= 0, d <= d+1 modulo 4 (3 wraps to 0).
REQ-017 Registered outputs SHALL reflect the state entered on the same edge; frame length SHALL be exactly 4*(GUARD+DIV) cycles.
REQ-018 Decoder output is defined only for nibbles 0-9; for a nibble > 9 the block SHALL force an = 4'hF and seg = 7'h7F for that dwell, and SHALL pulse bad_digit for one cycle on the SHOW entry edge.
REQ-019 With lz_blank = 1, digit d in {3,2,1} SHALL be blanked (an = 4'hF, seg = 7'h7F) when active digits d..3 are all zero; digit 0 SHALL never be lz-blanked.
REQ-020 With lz_blank = 0, every digit 0-9 SHALL be displayed.
REQ-021 load = 1 SHALL write val into shadow and set pending on the same edge; a second load before commit SHALL overwrite shadow (last load wins).
REQ-022 On the edge leaving SHOW with d = 3: frame_done SHALL assert for the following cycle; if pending, active <= shadow and pending <= 0 (tear-free update).
REQ-023 When load coincides with the commit edge: active SHALL take the pre-edge shadow, shadow SHALL take the new val, and pending SHALL remain 1.
REQ-024 When load coincides with the commit edge and pending = 0: active SHALL be unchanged, shadow <= val, pending <= 1.

Reset
REQ-025 On rst: state GUARD, d = 0, cnt = 0, an = 4'hF, seg = 7'h7F, active = 16'h0000, shadow = 16'h0000, pending = 0, frame_done = 0, bad_digit = 0.
REQ-026 rst SHALL take priority over load and over every FSM transition; rst asserted mid-dwell SHALL restart at GUARD, digit 0, discarding any pending value.
REQ-027 After rst deasserts, the first an low (an = 4'b1110) SHALL appear exactly GUARD cycles later.

Verification (DIV = 4, GUARD = 1, frame = 20 cycles)
REQ-028 Reset, lz_blank = 0, no load -> each frame: 1 off cycle then an = 1110 with seg = 7'b1000000 for 4 cycles, repeated for 1101/1011/0111; frame_done every 20 cycles.
REQ-029 load val = 16'h1234 mid-frame -> pending = 1 until frame end; next frame shows digit 0 = 7'b0011001 (4), digit 3 = 7'b1111001 (1); pending = 0 after commit.
REQ-030 Active = 16'h0042, lz_blank = 1 -> digits 3,2 an = 1111, seg = 7F; digit 1 = 7'b0011001 (4); digit 0 = 7'b0100100 (2). Active = 0000 -> only digit 0 lit, showing 7'b1000000.
REQ-031 load 16'h00A7 -> after commit, digit 1 dwell blank with bad_digit pulsing once per frame; digit 0 = 7'b1111000 (7).
REQ-032 load 16'h1111 then 16'h2222 in one frame, plus load 16'h3333 on the commit edge -> next frame shows 2222, pending stays 1, following frame shows 3333.
REQ-033 rst pulsed during digit 2 dwell with pending = 1 -> outputs return to reset values next cycle; an = 1110 after 1 cycle, showing 0; pending = 0.
